// File: rtl/pipeline_flops.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_flops
//  Brief    : Fixed-latency register pipeline. NUM_STAGES chained registers of
//             DATA_WIDTH bits, shifting every clock, synchronous active-low
//             reset clears every stage.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_flops #(
    parameter int NUM_STAGES = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] inp,
    output logic [DATA_WIDTH-1:0] out_top
);

    // Out-of-range parameters stop elaboration instead of being truncated.
    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 64) begin : g_bad_num_stages
            $error("pipeline_flops: NUM_STAGES=%0d outside 1..64", NUM_STAGES);
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_data_width
            $error("pipeline_flops: DATA_WIDTH=%0d outside 1..1024", DATA_WIDTH);
        end
    endgenerate

    // Index 0 is stage 1 (fed from inp); index NUM_STAGES-1 drives out_top.
    logic [DATA_WIDTH-1:0] r_stage [NUM_STAGES];

    // Shift the whole chain every edge; reset clears every stage so no
    // in-flight word survives a reset edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= inp;
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // Output comes straight from the last register: no path from inp.
    assign out_top = r_stage[NUM_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_flops.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_flops
//  Brief    : Self-checking bench for pipeline_flops at NUM_STAGES 1, 2, 3, 8
//             against a sample-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_flops;

    localparam int W = 16;

    logic         clk  = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] inp  = '0;
    logic [W-1:0] out1, out2, out3, out8;

    // 10 ns clock
    always #5 clk = ~clk;

    pipeline_flops #(.NUM_STAGES(1), .DATA_WIDTH(W)) u_dut1 (
        .clk(clk), .rstn(rstn), .inp(inp), .out_top(out1));
    pipeline_flops #(.NUM_STAGES(2), .DATA_WIDTH(W)) u_dut2 (
        .clk(clk), .rstn(rstn), .inp(inp), .out_top(out2));
    pipeline_flops #(.NUM_STAGES(3), .DATA_WIDTH(W)) u_dut3 (
        .clk(clk), .rstn(rstn), .inp(inp), .out_top(out3));
    pipeline_flops #(.NUM_STAGES(8), .DATA_WIDTH(W)) u_dut8 (
        .clk(clk), .rstn(rstn), .inp(inp), .out_top(out8));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every word seen on inp at edge e is samp[e]. The value
    // on an N-stage output after edge t is the word sampled at edge t-N+1,
    // unless a reset edge happened at or after that sampling edge, in which
    // case the output is zero.
    logic [W-1:0] samp [$];
    int           edge_n   = -1;
    int           last_rst = -1;
    bit           armed    = 1'b0;

    function automatic logic [W-1:0] expect_out(int n);
        int src;
        src = edge_n - n + 1;
        if (src <= last_rst) return '0;
        return samp[src];
    endfunction

    task automatic check(string tag, int n, logic [W-1:0] got);
        logic [W-1:0] exp;
        exp = expect_out(n);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s N=%0d edge=%0d observed=%h expected=%h",
                   tag, n, edge_n, got, exp);
        end
    endtask

    // One clock: drive at negedge, optionally pulse rstn low between edges,
    // advance the model at the posedge, check all outputs 1 ns later.
    task automatic step(string tag, logic r, logic [W-1:0] d, bit glitch = 1'b0);
        @(negedge clk);
        inp  = d;
        rstn = glitch ? 1'b0 : r;
        if (glitch) begin
            #2;
            rstn = r;
        end
        @(posedge clk);
        edge_n++;
        samp.push_back(d);
        if (!r) begin
            last_rst = edge_n;
            armed    = 1'b1;
        end
        #1;
        if (armed) begin
            check(tag, 1, out1);
            check(tag, 2, out2);
            check(tag, 3, out3);
            check(tag, 8, out8);
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] seq [4];
        seq[0] = 16'hA5A5; seq[1] = 16'h5A5A; seq[2] = 16'hFFFF; seq[3] = 16'h0000;

        // Reset held two edges with all-ones input
        step("reset_ffff", 1'b0, 16'hFFFF);
        step("reset_ffff", 1'b0, 16'hFFFF);

        // Release with zero, then a single one
        step("release_zero", 1'b1, 16'h0000);
        step("first_one", 1'b1, 16'h0001);
        step("first_one_tail", 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) step("first_one_drain", 1'b1, 16'h0000);

        // 1 x5, 0 x5, 1 x5 pattern, then drain
        for (int i = 0; i < 15; i++)
            step("pattern_5", 1'b1, (i >= 5 && i < 10) ? 16'h0000 : 16'h0001);
        for (int i = 0; i < 8; i++) step("pattern_drain", 1'b1, 16'h0000);

        // Back-to-back words, no gaps
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) step("b2b_words", 1'b1, seq[i]);

        // Two nonzero words then a one-edge reset discards them
        step("preload", 1'b1, 16'h1234);
        step("preload", 1'b1, 16'hBEEF);
        step("midstream_rst", 1'b0, 16'hCAFE);
        for (int i = 0; i < 9; i++) step("post_rst", 1'b1, 16'h0000);

        // rstn pulse between edges has no effect
        step("glitch_fill", 1'b1, 16'h7E57);
        step("glitch_fill", 1'b1, 16'h0F0F);
        step("rstn_glitch", 1'b1, 16'h3C3C, 1'b1);
        for (int i = 0; i < 8; i++) step("glitch_drain", 1'b1, 16'h0000);

        // Random words with occasional resets and glitches
        for (int i = 0; i < 300; i++) begin
            logic         r;
            bit           g;
            logic [W-1:0] d;
            r = ($urandom_range(0, 24) != 0);
            g = r && ($urandom_range(0, 19) == 0);
            d = W'($urandom);
            step("random", r, d, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
